uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- Frame-level controller for the UART receiver; sits directly downstream of edge_bit_counter and the 3-tap data sampler.
- Drives the counter Enable and consumes bit_cnt/edge_cnt and sampled_bit.
- Validates the start bit, deserializes LSB-first data, and checks optional parity and the stop bit.
- Presents P_DATA with a one-cycle data_valid strobe for error-free frames only.

Parameters:
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_BITS, 5, width of prescale and edge_cnt
- TX_BITS, 4, width of bit_cnt; must hold DATA_WIDTH+2

Ports:
- CLK  input  1  system clock (oversampling clock)
- RST  input  1  asynchronous reset, active-low
- RX_IN  input  1  serial line, idle high
- PAR_EN  input  1  parity bit present when 1
- PAR_TYP  input  1  0 = even, 1 = odd
- prescale  input  PRESCALE_BITS  oversample ratio; legal values 8 and 16
- bit_cnt  input  TX_BITS  from edge_bit_counter
- edge_cnt  input  PRESCALE_BITS  from edge_bit_counter
- sampled_bit  input  1  majority-voted bit from sampler; stable by edge_cnt = prescale-1
- cnt_enable  output  1  Enable to edge_bit_counter
- samp_en  output  1  enable to data sampler
- P_DATA  output  DATA_WIDTH  last good byte
- data_valid  output  1  one-cycle strobe on P_DATA update
- par_err  output  1  parity error of current/last frame
- stp_err  output  1  stop error of current/last frame

Behaviour:
- Reset values: state IDLE; cnt_enable 0; samp_en 0; P_DATA 0; data_valid 0; par_err 0; stp_err 0; shift register 0; latched PAR_EN/PAR_TYP 0.
- States: IDLE, START, DATA, PARITY, STOP. State is registered.
- cnt_enable = samp_en = (state != IDLE). Both are combinational from the state register.
- bit_end = cnt_enable && (edge_cnt == prescale-1). Every bit decision is taken only on bit_end.
- IDLE, RX_IN == 0:
  - Go to START.
  - Latch PAR_EN and PAR_TYP; they are held for the whole frame, so mid-frame input changes are ignored.
  - Clear par_err and stp_err.
- In START, counters begin at edge_cnt = 0, bit_cnt = 0 (they are held at 0 while disabled).
- START, bit_end:
  - sampled_bit == 0: go to DATA.
  - sampled_bit == 1: glitch; go to IDLE with no output strobe.
- DATA, bit_end (bit_cnt 1..DATA_WIDTH):
  - Shift right; sampled_bit enters the MSB, so the first data bit ends in the LSB.
  - At bit_cnt == DATA_WIDTH: go to PARITY if latched PAR_EN, else STOP.
- PARITY, bit_end:
  - Expected parity = XOR of the shift register, inverted when latched PAR_TYP = 1.
  - par_err <= (sampled_bit != expected). Go to STOP.
- STOP, bit_end:
  - stp_err <= ~sampled_bit.
  - If par_err is 0 and sampled_bit is 1: P_DATA <= shift register and data_valid = 1 for exactly one cycle (the cycle after bit_end).
  - Go to IDLE.
- Frame with errors: P_DATA is unchanged, no data_valid, and the error flags hold until the next start edge.
- Back-to-back frames:
  - After STOP→IDLE, the counters clear on the next edge because Enable is low.
  - A start edge already low on the first IDLE cycle is accepted: START is entered 1 cycle later with counters at 0.
- Latency: data_valid rises 1 cycle after bit_end of the stop bit.
- RX_IN transitions in DATA, PARITY or STOP are ignored except through sampled_bit.
- Reset mid-frame: immediately return to the reset values; the partial byte is discarded.
- Illegal prescale is not supported; behaviour is unspecified.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state encoding localparams (IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4; 3 bits)
  - PAR_EVEN/PAR_ODD constants
  - legal prescale constants.
- One natural sub-module: uart_rx_deser.
  - Shift register plus parity calculation.
  - Ports: CLK, RST, shift_en, sampled_bit, clear, data, parity.
- The FSM stays in uart_rx_fsm.

Test Plan:
- prescale = 8, PAR_EN = 1, even parity, byte 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0, stop 1) → P_DATA = 0xA5; data_valid high for 1 cycle, 1 cycle after stop bit_end; par_err = 0; stp_err = 0.
- Same frame with parity bit 1 → par_err = 1, no data_valid, P_DATA unchanged.
- prescale = 16, PAR_EN = 0, byte 0x3C with stop bit 0 → stp_err = 1, no data_valid; stp_err clears on the next start edge.
- RX_IN low for 2 cycles then high (glitch), prescale = 8 → START entered, back to IDLE on start bit_end; no outputs change; cnt_enable low afterwards.
- Two back-to-back frames, 0x55 then 0xFF, no idle gap, PAR_EN = 0 → two data_valid pulses; P_DATA = 0x55 then 0xFF.
- RST asserted during DATA (bit_cnt = 4), then a clean frame 0x81 → all outputs at reset values immediately; next frame yields P_DATA = 0x81.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: state encoding,
// parity type constants and the legal oversample ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [4:0] PRESCALE_8  = 5'd8;
    localparam logic [4:0] PRESCALE_16 = 5'd16;

endpackage

// File: rtl/uart_rx_deser.sv
// LSB-first deserializer: each shifted bit enters at the MSB so the first
// received data bit ends up in bit 0. Also supplies the XOR of the byte.
module uart_rx_deser #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  shift_en,
    input  logic                  sampled_bit,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  parity
);

    logic [DATA_WIDTH-1:0] shift_r;

    function automatic logic xor_reduce(input logic [DATA_WIDTH-1:0] value);
        return ^value;
    endfunction

    // Shift register: cleared at frame start, shifts right on each data bit_end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_r <= {DATA_WIDTH{1'b0}};
        end else if (clear) begin
            shift_r <= {DATA_WIDTH{1'b0}};
        end else if (shift_en) begin
            shift_r <= {sampled_bit, shift_r[DATA_WIDTH-1:1]};
        end
    end

    assign data   = shift_r;
    assign parity = xor_reduce(shift_r);

endmodule

// File: rtl/uart_rx_fsm.sv
// Frame-level UART receive controller. Enables the edge/bit counter while a
// frame is in progress, validates the start bit, collects data bits, checks
// optional parity and the stop bit, and strobes data_valid on good frames.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int PRESCALE_BITS = 5,
    parameter int TX_BITS       = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RX_IN,
    input  logic                     PAR_EN,
    input  logic                     PAR_TYP,
    input  logic [PRESCALE_BITS-1:0] prescale,
    input  logic [TX_BITS-1:0]       bit_cnt,
    input  logic [PRESCALE_BITS-1:0] edge_cnt,
    input  logic                     sampled_bit,
    output logic                     cnt_enable,
    output logic                     samp_en,
    output logic [DATA_WIDTH-1:0]    P_DATA,
    output logic                     data_valid,
    output logic                     par_err,
    output logic                     stp_err
);

    localparam logic [PRESCALE_BITS-1:0] EDGE_ONE  = PRESCALE_BITS'(1);
    localparam logic [TX_BITS-1:0]       LAST_DATA = TX_BITS'(DATA_WIDTH);

    rx_state_e             state_r;
    rx_state_e             state_next_s;
    logic                  bit_end_s;
    logic                  start_s;
    logic                  shift_s;
    logic                  par_chk_s;
    logic                  stop_chk_s;
    logic                  load_s;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  parity_s;
    logic                  par_exp_s;
    logic [DATA_WIDTH-1:0] shift_data_s;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  data_valid_r;
    logic                  par_err_r;
    logic                  stp_err_r;

    assign cnt_enable = (state_r != IDLE);
    assign samp_en    = (state_r != IDLE);
    assign bit_end_s  = cnt_enable && (edge_cnt == (prescale - EDGE_ONE));
    assign par_exp_s  = (par_typ_r == PAR_ODD) ? ~parity_s : parity_s;
    assign load_s     = stop_chk_s && sampled_bit && !par_err_r;

    uart_rx_deser #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deser (
        .CLK         (CLK),
        .RST         (RST),
        .shift_en    (shift_s),
        .sampled_bit (sampled_bit),
        .clear       (start_s),
        .data        (shift_data_s),
        .parity      (parity_s)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-bit decision strobes
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        shift_s      = 1'b0;
        par_chk_s    = 1'b0;
        stop_chk_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!RX_IN) begin
                    state_next_s = START;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    // A start bit that reads back high is a line glitch
                    state_next_s = sampled_bit ? IDLE : DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_s = 1'b1;
                    if (bit_cnt == LAST_DATA) begin
                        state_next_s = par_en_r ? PARITY : STOP;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    par_chk_s    = 1'b1;
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    stop_chk_s   = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Frame configuration is captured on the start edge and held for the frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else if (start_s) begin
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
        end
    end

    // Output registers: error flags, received byte and valid strobe
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_data_r     <= {DATA_WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
        end else begin
            data_valid_r <= load_s;
            if (start_s) begin
                par_err_r <= 1'b0;
                stp_err_r <= 1'b0;
            end else begin
                if (par_chk_s) begin
                    par_err_r <= (sampled_bit != par_exp_s);
                end
                if (stop_chk_s) begin
                    stp_err_r <= ~sampled_bit;
                end
            end
            if (load_s) begin
                p_data_r <= shift_data_s;
            end
        end
    end

    assign P_DATA     = p_data_r;
    assign data_valid = data_valid_r;
    assign par_err    = par_err_r;
    assign stp_err    = stp_err_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm. Models the edge/bit counter and an ideal
// sampler (sampled_bit follows RX_IN) and drives whole frames bit by bit.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [4:0] prescale;
    logic [3:0] bit_cnt;
    logic [4:0] edge_cnt;
    logic       sampled_bit;
    logic       cnt_enable;
    logic       samp_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int n_tests = 0;
    int n_fail  = 0;
    int dv_count = 0;

    uart_rx_fsm dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .prescale    (prescale),
        .bit_cnt     (bit_cnt),
        .edge_cnt    (edge_cnt),
        .sampled_bit (sampled_bit),
        .cnt_enable  (cnt_enable),
        .samp_en     (samp_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign sampled_bit = RX_IN;

    // Edge/bit counter model: held at zero while disabled
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else if (!cnt_enable) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else if (edge_cnt == prescale - 5'd1) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    // Count data_valid pulses, sampled away from the active edge
    always @(negedge CLK) begin
        if (data_valid === 1'b1) dv_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Send one frame; PAR_EN/PAR_TYP are flipped after the start bit so a
    // design that does not hold its latched configuration misframes.
    task automatic send_frame(input logic [7:0] b, input logic pe, input logic pbit,
                              input logic stop, input logic pt);
        int p;
        p = int'(prescale);
        PAR_EN  = pe;
        PAR_TYP = pt;
        drive_bit(1'b0, p + 1);
        PAR_EN  = ~pe;
        PAR_TYP = ~pt;
        for (int i = 0; i < 8; i++) drive_bit(b[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit(stop, p);
        PAR_EN  = pe;
        PAR_TYP = pt;
    endtask

    initial begin
        RST      = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = PAR_EVEN;
        prescale = PRESCALE_8;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cnt_enable", 32'(cnt_enable), 32'd0);
        check("rst_samp_en",    32'(samp_en),    32'd0);
        check("rst_p_data",     32'(P_DATA),     32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_par_err",    32'(par_err),    32'd0);
        check("rst_stp_err",    32'(stp_err),    32'd0);
        RST = 1'b1;
        idle(4);

        // Good frame 0xA5, even parity, prescale 8
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, PAR_EVEN);
        check("a5_dv_after_stop", 32'(data_valid), 32'd1);
        check("a5_p_data",        32'(P_DATA),     32'h0000_00A5);
        check("a5_par_err",       32'(par_err),    32'd0);
        check("a5_stp_err",       32'(stp_err),    32'd0);
        check("a5_back_to_idle",  32'(cnt_enable), 32'd0);
        idle(1);
        check("a5_dv_one_cycle",  32'(data_valid), 32'd0);
        check("a5_dv_count",      32'(dv_count),   32'd1);
        idle(4);

        // Same frame with wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, PAR_EVEN);
        check("perr_par_err", 32'(par_err),    32'd1);
        check("perr_stp_err", 32'(stp_err),    32'd0);
        check("perr_dv",      32'(data_valid), 32'd0);
        check("perr_p_data",  32'(P_DATA),     32'h0000_00A5);
        idle(2);
        check("perr_dv_count", 32'(dv_count),  32'd1);

        // Odd parity: 0x07 has three ones, odd parity bit is 0
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, PAR_ODD);
        check("odd_dv",      32'(data_valid), 32'd1);
        check("odd_p_data",  32'(P_DATA),     32'h0000_0007);
        check("odd_par_err", 32'(par_err),    32'd0);
        idle(4);

        // Stop error at prescale 16, no parity
        prescale = PRESCALE_16;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, PAR_EVEN);
        RX_IN = 1'b1;
        check("serr_stp_err", 32'(stp_err),    32'd1);
        check("serr_par_err", 32'(par_err),    32'd0);
        check("serr_dv",      32'(data_valid), 32'd0);
        check("serr_p_data",  32'(P_DATA),     32'h0000_0007);
        idle(5);
        check("serr_holds",   32'(stp_err),    32'd1);
        drive_bit(1'b0, 1);
        check("serr_clear_on_start", 32'(stp_err),    32'd0);
        check("serr_start_enable",   32'(cnt_enable), 32'd1);
        drive_bit(1'b0, 1);
        idle(20);
        check("serr_glitch_idle", 32'(cnt_enable), 32'd0);

        // Glitch at prescale 8
        prescale = PRESCALE_8;
        idle(2);
        drive_bit(1'b0, 1);
        check("glitch_cnt_enable", 32'(cnt_enable), 32'd1);
        check("glitch_samp_en",    32'(samp_en),    32'd1);
        drive_bit(1'b0, 1);
        idle(12);
        check("glitch_idle",     32'(cnt_enable), 32'd0);
        check("glitch_dv_count", 32'(dv_count),   32'd2);
        check("glitch_p_data",   32'(P_DATA),     32'h0000_0007);
        check("glitch_stp_err",  32'(stp_err),    32'd0);

        // Back-to-back frames, no idle gap
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, PAR_EVEN);
        check("b2b_dv1",     32'(data_valid), 32'd1);
        check("b2b_p_data1", 32'(P_DATA),     32'h0000_0055);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, PAR_EVEN);
        check("b2b_dv2",     32'(data_valid), 32'd1);
        check("b2b_p_data2", 32'(P_DATA),     32'h0000_00FF);
        idle(2);
        check("b2b_dv_count", 32'(dv_count), 32'd4);

        // Reset during DATA with bit_cnt = 4
        idle(3);
        PAR_EN = 1'b0;
        drive_bit(1'b0, 9);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        check("mid_bit_cnt",    32'(bit_cnt),    32'd4);
        check("mid_cnt_enable", 32'(cnt_enable), 32'd1);
        RST = 1'b0;
        #1;
        check("mid_rst_cnt_enable", 32'(cnt_enable), 32'd0);
        check("mid_rst_samp_en",    32'(samp_en),    32'd0);
        check("mid_rst_p_data",     32'(P_DATA),     32'd0);
        check("mid_rst_dv",         32'(data_valid), 32'd0);
        check("mid_rst_par_err",    32'(par_err),    32'd0);
        check("mid_rst_stp_err",    32'(stp_err),    32'd0);
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(3);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, PAR_EVEN);
        check("post_rst_dv",      32'(data_valid), 32'd1);
        check("post_rst_p_data",  32'(P_DATA),     32'h0000_0081);
        check("post_rst_stp_err", 32'(stp_err),    32'd0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
